mfp_gauss_kernel_streamer: RTL and testbench

//  Multi-scale Gaussian kernel coefficient source for the SIFT scale-space blur stage.

---
 rtl/mfp_gauss_kernel_streamer.sv | 172 +++++++++++++++++
 tb/tb_mfp_gauss_kernel_streamer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_gauss_kernel_streamer.sv
// Multi-scale Gaussian kernel coefficient source: streams one selected kernel tap by tap over valid/ready.
// Optional feature macro: MFP_GKS_SUM_EN adds a per-stream coefficient sum (sum_out/sum_valid).

module MFP_gaussianTable #(
    parameter real x       = 0.0,
    parameter real sig     = 1.0,
    parameter int  outputW = 18
) (
    output logic signed [outputW-1:0] value_o
);
    // Normalised Gaussian sample in Q1.(outputW-1), rounded to nearest and saturated to the positive range.
    localparam real PI     = 3.14159265358979323846;
    localparam real GAUSS  = $exp(-(x * x) / (2.0 * sig * sig)) / (sig * $sqrt(2.0 * PI));
    localparam real SCALED = GAUSS * (2.0 ** (outputW - 1)) + 0.5;
    localparam real MAXPOS = (2.0 ** (outputW - 1)) - 1.0;
    localparam int  VAL    = (SCALED > MAXPOS) ? $rtoi(MAXPOS) : $rtoi(SCALED);

    assign value_o = outputW'(VAL);
endmodule

module mfp_gauss_kernel_streamer #(
    parameter int  DATA_W   = 18,
    parameter int  KTAPS    = 9,
    parameter real XSTEP    = 1.0,
    parameter int  NSCALES  = 4,
    parameter real SIG0     = 1.6,
    parameter real SIG_STEP = 0.4,
    parameter int  IDX_W    = $clog2(KTAPS),
    parameter int  SCL_W    = (NSCALES > 1) ? $clog2(NSCALES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SCL_W-1:0]         scale_sel,
    output logic                     busy,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [DATA_W-1:0] coef_data,
    output logic [IDX_W-1:0]         coef_idx,
    output logic                     coef_last,
    output logic                     done
`ifdef MFP_GKS_SUM_EN
    ,
    output logic [DATA_W+IDX_W:0]    sum_out,
    output logic                     sum_valid
`endif
);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(KTAPS - 1);
    localparam logic [SCL_W:0]   NSC        = (SCL_W + 1)'(NSCALES);
    localparam logic [SCL_W-1:0] SCL_MAX    = SCL_W'(NSCALES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q;
    logic [SCL_W-1:0]           scale_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       busy_q, valid_q, last_q, done_q;
    logic signed [DATA_W-1:0]   data_q;

    logic [SCL_W-1:0]           selClamped_d, rdScale_d;
    logic [IDX_W-1:0]           idxNext_d, rdIdx_d;
    logic signed [DATA_W-1:0]   nextCoef_d;

    logic [NSCALES*KTAPS*DATA_W-1:0] coefTable_w;
    logic signed [DATA_W-1:0]        coefRom [NSCALES][KTAPS];

    for (genvar s = 0; s < NSCALES; s++) begin : gScale
        for (genvar i = 0; i < KTAPS; i++) begin : gTap
            MFP_gaussianTable #(
                .x       ((real'(i) - real'(KTAPS / 2)) * XSTEP),
                .sig     (SIG0 + real'(s) * SIG_STEP),
                .outputW (DATA_W)
            ) uTable (
                .value_o (coefTable_w[(s*KTAPS+i)*DATA_W +: DATA_W])
            );
            assign coefRom[s][i] = coefTable_w[(s*KTAPS+i)*DATA_W +: DATA_W];
        end
    end

    // In IDLE the read port pre-fetches tap 0 of the requested scale; in RUN it fetches the following tap.
    always_comb begin
        selClamped_d = ({1'b0, scale_sel} >= NSC) ? SCL_MAX : scale_sel;
        idxNext_d    = idx_q + 1'b1;
        rdScale_d    = (state_q == IDLE) ? selClamped_d : scale_q;
        rdIdx_d      = (state_q == IDLE) ? '0 : idxNext_d;
        nextCoef_d   = coefRom[rdScale_d][rdIdx_d];
    end

`ifdef MFP_GKS_SUM_EN
    logic [DATA_W+IDX_W:0] sumAcc_q, sumOut_q, beatExt_d;
    logic                  sumValid_q;

    assign beatExt_d = {{(IDX_W + 1){1'b0}}, data_q};
    assign sum_out   = sumOut_q;
    assign sum_valid = sumValid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sumAcc_q   <= '0;
            sumOut_q   <= '0;
            sumValid_q <= 1'b0;
        end else begin
            sumValid_q <= 1'b0;
            if (state_q == IDLE && start) begin
                sumAcc_q <= '0;
                sumOut_q <= '0;
            end else if (state_q == RUN && valid_q && coef_ready) begin
                sumAcc_q <= sumAcc_q + beatExt_d;
                if (idx_q == LAST_IDX) begin
                    sumOut_q   <= sumAcc_q + beatExt_d;
                    sumValid_q <= 1'b1;
                end
            end
        end
    end
`else
    // Without the sum feature there is no accumulator and no sum ports.
`endif

    // Beat payload only advances on an accepted transfer, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            scale_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        scale_q <= selClamped_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        data_q  <= nextCoef_d;
                        last_q  <= (LAST_IDX == '0);
                    end
                end
                RUN: begin
                    if (valid_q && coef_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idxNext_d;
                            data_q <= nextCoef_d;
                            last_q <= (idxNext_d == LAST_IDX);
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign coef_valid = valid_q;
    assign coef_data  = data_q;
    assign coef_idx   = idx_q;
    assign coef_last  = last_q;
    assign done       = done_q;
endmodule

// File: tb/tb_mfp_gauss_kernel_streamer.sv
// Directed bench for mfp_gauss_kernel_streamer with a beat scoreboard fed from a Gaussian reference model.
// Sum checks are compiled in when MFP_GKS_SUM_EN is defined.

module tb_mfp_gauss_kernel_streamer;
    localparam int  DATA_W   = 18;
    localparam int  KTAPS    = 9;
    localparam real XSTEP    = 1.0;
    localparam int  NSCALES  = 4;
    localparam real SIG0     = 1.6;
    localparam real SIG_STEP = 0.4;
    localparam int  IDX_W    = 4;
    localparam int  SCL_W    = 2;

    typedef struct packed {
        logic [IDX_W-1:0]         idx;
        logic signed [DATA_W-1:0] data;
        logic                     last;
    } beat_t;

    beat_t expQ[$];

    logic                     clk = 1'b0;
    logic                     rst, start, coef_ready;
    logic [SCL_W-1:0]         scale_sel;
    logic                     busy, coef_valid, coef_last, done;
    logic signed [DATA_W-1:0] coef_data;
    logic [IDX_W-1:0]         coef_idx;
`ifdef MFP_GKS_SUM_EN
    logic [DATA_W+IDX_W:0]    sum_out;
    logic                     sum_valid;
`endif

    int      testsRun = 0;
    int      failCount = 0;
    int      cycleCount = 0;
    int      doneCount = 0;
    int      startEdge, t0, dc;
    longint  expSum;
    logic signed [DATA_W-1:0] recTaps [KTAPS];
    logic signed [DATA_W-1:0] scale0Taps [KTAPS];

    mfp_gauss_kernel_streamer #(
        .DATA_W(DATA_W), .KTAPS(KTAPS), .XSTEP(XSTEP), .NSCALES(NSCALES),
        .SIG0(SIG0), .SIG_STEP(SIG_STEP), .IDX_W(IDX_W), .SCL_W(SCL_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .scale_sel(scale_sel), .busy(busy),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .coef_idx(coef_idx), .coef_last(coef_last), .done(done)
`ifdef MFP_GKS_SUM_EN
        , .sum_out(sum_out), .sum_valid(sum_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference coefficient: normalised Gaussian in Q1.(DATA_W-1), rounded to nearest.
    function automatic int refCoef(input int s, input int i);
        real sig, x, g;
        sig = SIG0 + real'(s) * SIG_STEP;
        x   = (real'(i) - real'(KTAPS / 2)) * XSTEP;
        g   = $exp(-(x * x) / (2.0 * sig * sig)) / (sig * $sqrt(2.0 * 3.14159265358979323846));
        return $rtoi(g * (2.0 ** (DATA_W - 1)) + 0.5);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every accepted beat is popped and compared; taps are recorded for shape checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (coef_valid && coef_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", {63'd0, coef_valid}, 64'd0);
                end else begin
                    checkOutput("beatIdx", {60'd0, coef_idx}, {60'd0, expQ[0].idx});
                    checkOutput("beatData", 64'(coef_data), 64'(expQ[0].data));
                    checkOutput("beatLast", {63'd0, coef_last}, {63'd0, expQ[0].last});
                    expQ.delete(0);
                end
                recTaps[coef_idx] <= coef_data;
            end
            if (done) doneCount <= doneCount + 1;
`ifdef MFP_GKS_SUM_EN
            if (done || sum_valid) begin
                checkOutput("sumValid", {63'd0, sum_valid}, {63'd0, done});
                checkOutput("sumOut", 64'(sum_out), 64'(expSum));
            end
`endif
        end
    end

    task automatic applyStimulus(input int sel, input int modelScale);
        start     = 1'b1;
        scale_sel = SCL_W'(sel);
        expSum    = 0;
        for (int i = 0; i < KTAPS; i++) begin
            expQ.push_back('{idx: IDX_W'(i), data: DATA_W'(refCoef(modelScale, i)), last: (i == KTAPS - 1)});
            expSum += refCoef(modelScale, i);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        startEdge = cycleCount;
        checkOutput("startValid", {63'd0, coef_valid}, 64'd1);
        checkOutput("startIdx", {60'd0, coef_idx}, 64'd0);
        checkOutput("startBusy", {63'd0, busy}, 64'd1);
`ifdef MFP_GKS_SUM_EN
        checkOutput("sumCleared", 64'(sum_out), 64'd0);
`endif
    endtask

    task automatic waitDone(input string tag, input int expectCycle);
        for (int n = 0; n < 60 && done !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "Done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "Cycle"}, 64'(cycleCount), 64'(expectCycle));
        checkOutput({tag, "QueueEmpty"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, "BusyLow"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        coef_ready = 1'b1;
        scale_sel  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", {63'd0, coef_valid}, 64'd0);
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        checkOutput("rstDone", {63'd0, done}, 64'd0);
        checkOutput("rstLast", {63'd0, coef_last}, 64'd0);
        checkOutput("rstData", 64'(coef_data), 64'd0);
        checkOutput("rstIdx", {60'd0, coef_idx}, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleNoBeat", {63'd0, coef_valid}, 64'd0);

        // Free-running stream of scale 0.
        applyStimulus(0, 0);
        waitDone("freeRun", startEdge + 9);
        for (int i = 0; i < KTAPS; i++) scale0Taps[i] = recTaps[i];
        for (int i = 0; i < KTAPS / 2; i++) begin
            checkOutput("symmetry", 64'(recTaps[i]), 64'(recTaps[KTAPS-1-i]));
            checkOutput("centreMax", {63'd0, recTaps[KTAPS/2] > recTaps[i]}, 64'd1);
        end
        @(posedge clk); #1;
        checkOutput("donePulseOnce", {63'd0, done}, 64'd0);
        checkOutput("idleAfterDone", {63'd0, coef_valid}, 64'd0);

        // Backpressure: hold ready low for three cycles while tap 2 is presented.
        applyStimulus(0, 0);
        t0 = startEdge;
        repeat (2) begin @(posedge clk); #1; end
        coef_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("holdIdx", {60'd0, coef_idx}, 64'd2);
            checkOutput("holdData", 64'(coef_data), 64'(DATA_W'(refCoef(0, 2))));
            checkOutput("holdValid", {63'd0, coef_valid}, 64'd1);
        end
        coef_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("resumeIdx", {60'd0, coef_idx}, 64'd3);
        waitDone("backpressure", t0 + 12);
        @(posedge clk); #1;

        // Scale selection and out-of-range select.
        applyStimulus(1, 1);
        waitDone("scale1", startEdge + 9);
        checkOutput("centreSmaller", {63'd0, recTaps[KTAPS/2] < scale0Taps[KTAPS/2]}, 64'd1);
        @(posedge clk); #1;
        applyStimulus(7, 3);
        waitDone("clamp", startEdge + 9);
        @(posedge clk); #1;

        // Starts while busy and in the DONE cycle are ignored; first IDLE cycle start is accepted.
        applyStimulus(0, 0);
        t0 = startEdge;
        dc = doneCount;
        repeat (3) begin @(posedge clk); #1; end
        start     = 1'b1;
        scale_sel = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busyStartIgnored", {60'd0, coef_idx}, 64'd4);
        waitDone("ignoredStart", t0 + 9);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("doneCycleStartIgnored", {63'd0, coef_valid}, 64'd0);
        checkOutput("singleDone", 64'(doneCount - dc), 64'd1);
        applyStimulus(0, 0);
        waitDone("backToBack", startEdge + 9);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a stream.
        applyStimulus(0, 0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checkOutput("abortValid", {63'd0, coef_valid}, 64'd0);
        checkOutput("abortBusy", {63'd0, busy}, 64'd0);
        checkOutput("abortDone", {63'd0, done}, 64'd0);
        expQ.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("postAbortIdle", {63'd0, coef_valid}, 64'd0);
        checkOutput("postAbortNoDone", {63'd0, done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
